adder16_cla: RTL and testbench

- 16-bit unsigned adder used by the multiplier datapath (Multiplicador) to accumulate partial products.
- Produces a 17-bit sum: bit 16 is the carry-out.
- Provides a zero-latency combinational sum, plus a registered copy with a valid flag for pipelined use.
- Core is a carry-lookahead adder built from 4-bit CLA groups.

---
 rtl/mult_pkg.sv | 8 +
 rtl/adder16_cla_if.sv | 21 ++
 rtl/cla4_group.sv | 29 ++
 rtl/adder16_cla.sv | 80 ++++++++
 tb/tb_adder16_cla.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared widths and types for the multiplier datapath adder.
package mult_pkg;
    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_GROUP = 4;

    typedef logic [ADDER_WIDTH-1:0] operand_t;
    typedef logic [ADDER_WIDTH:0]   soma_t;
endpackage

// File: rtl/adder16_cla_if.sv
// Operand/result bundle between the partial-product accumulator and the CLA adder.
interface adder16_cla_if;
    import mult_pkg::*;

    logic     Entrada_Valida;
    operand_t OperandoA;
    operand_t OperandoB;
    soma_t    Soma;
    soma_t    Soma_Reg;
    logic     Saida_Valida;

    modport master (
        output Entrada_Valida, OperandoA, OperandoB,
        input  Soma, Soma_Reg, Saida_Valida
    );

    modport slave (
        input  Entrada_Valida, OperandoA, OperandoB,
        output Soma, Soma_Reg, Saida_Valida
    );
endinterface

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: local sum from its carry-in plus group generate/propagate.
module cla4_group (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_g,
    output logic       o_p
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;

    // Group terms are independent of i_cin so the upper lookahead level never waits on it.
    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign o_p = &w_p;
endmodule

// File: rtl/adder16_cla.sv
// Two-level carry-lookahead adder with combinational sum and a registered, valid-tagged copy.
module adder16_cla
    import mult_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int GROUP = ADDER_GROUP
) (
    input  logic         Clock,
    input  logic         Reset_n,
    adder16_cla_if.slave bus
);
    localparam int NG = WIDTH / GROUP;

    logic [NG-1:0]  w_grp_g;
    logic [NG-1:0]  w_grp_p;
    logic [NG:0]    w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0] w_soma;

    logic [WIDTH:0] r_soma_reg;
    logic           r_saida_valida;

    // Carry into group k as a flat sum of products over lower groups (carry-in to group 0 is 0).
    function automatic logic lookahead_carry(
        input logic [NG-1:0] g,
        input logic [NG-1:0] p,
        input int            k
    );
        logic c;
        logic term;
        c = 1'b0;
        for (int j = 0; j < NG; j++) begin
            if (j < k) begin
                term = g[j];
                for (int m = 0; m < NG; m++) begin
                    if ((m > j) && (m < k)) begin
                        term = term & p[m];
                    end
                end
                c = c | term;
            end
        end
        return c;
    endfunction

    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_group
            cla4_group u_grp (
                .i_a   (bus.OperandoA[gi*GROUP +: GROUP]),
                .i_b   (bus.OperandoB[gi*GROUP +: GROUP]),
                .i_cin (w_carry[gi]),
                .o_sum (w_sum[gi*GROUP +: GROUP]),
                .o_g   (w_grp_g[gi]),
                .o_p   (w_grp_p[gi])
            );

            assign w_carry[gi+1] = lookahead_carry(w_grp_g, w_grp_p, gi + 1);
        end
    endgenerate

    assign w_soma = {w_carry[NG], w_sum};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_soma_reg     <= '0;
            r_saida_valida <= 1'b0;
        end else if (bus.Entrada_Valida) begin
            r_soma_reg     <= w_soma;
            r_saida_valida <= 1'b1;
        end else begin
            r_saida_valida <= 1'b0;
        end
    end

    assign bus.Soma         = w_soma;
    assign bus.Soma_Reg     = r_soma_reg;
    assign bus.Saida_Valida = r_saida_valida;
endmodule

// File: tb/tb_adder16_cla.sv
// Directed and reference-sum checks of the CLA adder, combinational and registered paths.
module tb_adder16_cla;
    import mult_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    adder16_cla_if bus ();

    adder16_cla dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end else begin
            $display("ok   %s: %05h", tag, got);
        end
    endtask

    task automatic comb_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] exp);
        bus.OperandoA = a;
        bus.OperandoB = b;
        #1;
        check_val(tag, bus.Soma, exp);
    endtask

    logic [15:0] vec_a [13];
    logic [15:0] vec_b [13];
    logic [16:0] vec_s [13];

    initial begin
        vec_a = '{16'd3, 16'd15, 16'd7, 16'd0, 16'd9,
                  16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF,
                  16'hFFFF, 16'h8000, 16'hAAAA, 16'h1234};
        vec_b = '{16'd5, 16'd1, 16'd8, 16'd0, 16'd6,
                  16'h0001, 16'h0001, 16'h0001, 16'h0001,
                  16'hFFFF, 16'h8000, 16'h5555, 16'h4321};
        vec_s = '{17'd8, 17'd16, 17'd15, 17'd0, 17'd15,
                  17'h00010, 17'h00100, 17'h01000, 17'h10000,
                  17'h1FFFE, 17'h10000, 17'h0FFFF, 17'h05555};

        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.Entrada_Valida = 1'b0;
        bus.OperandoA = '0;
        bus.OperandoB = '0;
        #1;
        check_val("reset_soma_reg", bus.Soma_Reg, 17'd0);
        check_val("reset_valid", {16'd0, bus.Saida_Valida}, 17'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            comb_vec($sformatf("comb_%0d", i), vec_a[i], vec_b[i], vec_s[i]);
        end

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            bus.OperandoA = ra;
            bus.OperandoB = rb;
            #1;
            if (bus.Soma !== ({1'b0, ra} + {1'b0, rb})) begin
                check_val($sformatf("rand_%0d", i), bus.Soma, {1'b0, ra} + {1'b0, rb});
            end else begin
                n_vec++;
            end
        end

        // Registered path: capture, hold, then back-to-back.
        @(negedge clk);
        bus.Entrada_Valida = 1'b1;
        bus.OperandoA = 16'd3;
        bus.OperandoB = 16'd5;
        @(posedge clk); #1;
        check_val("reg_capture", bus.Soma_Reg, 17'd8);
        check_val("reg_valid_hi", {16'd0, bus.Saida_Valida}, 17'd1);

        @(negedge clk);
        bus.Entrada_Valida = 1'b0;
        bus.OperandoA = 16'd1;
        bus.OperandoB = 16'd1;
        @(posedge clk); #1;
        check_val("reg_hold", bus.Soma_Reg, 17'd8);
        check_val("reg_valid_lo", {16'd0, bus.Saida_Valida}, 17'd0);

        @(negedge clk);
        bus.Entrada_Valida = 1'b1;
        bus.OperandoA = 16'd1;
        bus.OperandoB = 16'd2;
        @(posedge clk); #1;
        check_val("b2b_first", bus.Soma_Reg, 17'd3);
        check_val("b2b_first_valid", {16'd0, bus.Saida_Valida}, 17'd1);
        @(negedge clk);
        bus.OperandoA = 16'd4;
        bus.OperandoB = 16'd4;
        @(posedge clk); #1;
        check_val("b2b_second", bus.Soma_Reg, 17'd8);
        check_val("b2b_second_valid", {16'd0, bus.Saida_Valida}, 17'd1);

        // Asynchronous reset between edges while Soma_Reg holds 8.
        @(negedge clk);
        bus.Entrada_Valida = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_reg", bus.Soma_Reg, 17'd0);
        check_val("async_rst_valid", {16'd0, bus.Saida_Valida}, 17'd0);
        bus.OperandoA = 16'd10;
        bus.OperandoB = 16'd20;
        #1;
        check_val("soma_in_reset", bus.Soma, 17'd30);
        bus.Entrada_Valida = 1'b1;
        @(posedge clk); #1;
        check_val("rst_blocks_capture", bus.Soma_Reg, 17'd0);
        check_val("rst_blocks_valid", {16'd0, bus.Saida_Valida}, 17'd0);

        @(negedge clk);
        rst_n = 1'b1;
        bus.OperandoA = 16'd2;
        bus.OperandoB = 16'd2;
        @(posedge clk); #1;
        check_val("post_rst_capture", bus.Soma_Reg, 17'd4);
        check_val("post_rst_valid", {16'd0, bus.Saida_Valida}, 17'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
